// File: rtl/memory_dumper_pkg.sv
// Shared system package: dumper FSM state encoding and program RAM geometry
// (also used by the program loader and the RAM itself).
package memory_dumper_pkg;

    localparam int RAM_ADDR_WIDTH = 5;
    localparam int RAM_DATA_WIDTH = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic state_is_busy(input logic [2:0] state);
        return (state == ST_FETCH) || (state == ST_CAPTURE) || (state == ST_SEND);
    endfunction

endpackage

// File: rtl/memory_dumper.sv
// Post-halt RAM read-back: streams START_ADDR..END_ADDR over valid/ready with
// address, last flag and a modulo checksum of the accepted words.
module memory_dumper
    import memory_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_dump,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  dump_complete,
    output logic [DATA_WIDTH-1:0] checksum
);

    if (END_ADDR < START_ADDR) begin : g_bad_range
        $error("memory_dumper: END_ADDR must be >= START_ADDR");
    end

    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);

    logic [2:0]            state_r;
    logic [2:0]            state_next_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic                  out_last_r;
    logic                  busy_r;
    logic                  dump_complete_r;
    logic [DATA_WIDTH-1:0] checksum_r;
    logic                  handshake_s;

    assign handshake_s = out_valid_r && out_ready;

    // Next-state decode; start_dump only matters when no dump is in flight.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_dump) state_next_s = ST_FETCH;
                else            state_next_s = state_r;
            end
            ST_FETCH:   state_next_s = ST_CAPTURE;
            ST_CAPTURE: state_next_s = ST_SEND;
            ST_SEND: begin
                if (handshake_s) state_next_s = out_last_r ? ST_DONE : ST_FETCH;
                else             state_next_s = ST_SEND;
            end
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // State, address walk, output capture and checksum accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            mem_addr_r      <= START_A;
            out_valid_r     <= 1'b0;
            out_data_r      <= {DATA_WIDTH{1'b0}};
            out_addr_r      <= {ADDR_WIDTH{1'b0}};
            out_last_r      <= 1'b0;
            busy_r          <= 1'b0;
            dump_complete_r <= 1'b0;
            checksum_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r         <= state_next_s;
            busy_r          <= state_is_busy(state_next_s);
            dump_complete_r <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_dump) begin
                        mem_addr_r <= START_A;
                        checksum_r <= {DATA_WIDTH{1'b0}};
                    end
                end
                ST_FETCH: begin
                    mem_addr_r <= mem_addr_r;
                end
                // RAM data for mem_addr_r is valid during this cycle.
                ST_CAPTURE: begin
                    out_data_r  <= mem_read_data;
                    out_addr_r  <= mem_addr_r;
                    out_valid_r <= 1'b1;
                    out_last_r  <= (mem_addr_r == END_A);
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        checksum_r  <= checksum_r + out_data_r;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (!out_last_r) mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr      = mem_addr_r;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_addr      = out_addr_r;
    assign out_last      = out_last_r;
    assign busy          = busy_r;
    assign dump_complete = dump_complete_r;
    assign checksum      = checksum_r;

endmodule

// File: tb/tb_memory_dumper.sv
// Scoreboard bench for memory_dumper: full-range instance plus a single-word
// (7..7) instance, each with a registered-read RAM model and a beat monitor.
module tb_memory_dumper;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        start_a = 1'b0, ready_a = 1'b0;
    logic [4:0]  mem_addr_a, out_addr_a;
    logic [15:0] rd_a, out_data_a, checksum_a;
    logic        out_valid_a, out_last_a, busy_a, done_a;
    logic [15:0] mem_a [32];

    logic        start_b = 1'b0, ready_b = 1'b1;
    logic [4:0]  mem_addr_b, out_addr_b;
    logic [15:0] rd_b, out_data_b, checksum_b;
    logic        out_valid_b, out_last_b, busy_b, done_b;
    logic [15:0] mem_b [32];

    beat_t q_a[$];
    beat_t q_b[$];
    int compared = 0;
    int mismatched = 0;

    memory_dumper dut_a (
        .clock(clock), .reset(reset), .start_dump(start_a),
        .mem_addr(mem_addr_a), .mem_read_data(rd_a),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_data(out_data_a),
        .out_addr(out_addr_a), .out_last(out_last_a), .busy(busy_a),
        .dump_complete(done_a), .checksum(checksum_a)
    );

    memory_dumper #(.START_ADDR(7), .END_ADDR(7)) dut_b (
        .clock(clock), .reset(reset), .start_dump(start_b),
        .mem_addr(mem_addr_b), .mem_read_data(rd_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_data(out_data_b),
        .out_addr(out_addr_b), .out_last(out_last_b), .busy(busy_b),
        .dump_complete(done_b), .checksum(checksum_b)
    );

    always @(posedge clock) begin
        rd_a <= mem_a[mem_addr_a];
        rd_b <= mem_b[mem_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_beat", {27'd0, out_addr_a}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = q_a.pop_front();
                check("a_beat_addr", {27'd0, out_addr_a}, {27'd0, e.addr});
                check("a_beat_data", {16'd0, out_data_a}, {16'd0, e.data});
                check("a_beat_last", {31'd0, out_last_a}, {31'd0, e.last});
            end
        end
        if (!reset && out_valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_beat", {27'd0, out_addr_b}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = q_b.pop_front();
                check("b_beat_addr", {27'd0, out_addr_b}, {27'd0, e.addr});
                check("b_beat_data", {16'd0, out_data_b}, {16'd0, e.data});
                check("b_beat_last", {31'd0, out_last_b}, {31'd0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_range(input int first, input int last_idx);
        for (int i = first; i <= last_idx; i++) begin
            beat_t b;
            b.addr = 5'(i);
            b.data = mem_a[i];
            b.last = (i == 31);
            q_a.push_back(b);
        end
    endtask

    task automatic wait_valid_a(input string name);
        int n;
        n = 0;
        while (!out_valid_a && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid_a) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done_a(output int cycles);
        cycles = 0;
        while (!done_a && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    task automatic handshake_a();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [15:0] saved_sum;

        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 16'(i * 16'h0101);
            mem_b[i] = 16'h1111;
        end
        mem_b[7] = 16'hBEEF;

        repeat (3) tick();
        check("rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_checksum", {16'd0, checksum_a}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr_a}, 32'd0);
        check("rst_out_data", {16'd0, out_data_a}, 32'd0);
        check("rst_mem_addr_b", {27'd0, mem_addr_b}, 32'd7);
        reset = 1'b0;
        tick();

        // Full dump with the host always ready.
        push_range(0, 31);
        ready_a = 1'b1;
        start_pulse_a();
        wait_done_a(cyc);
        check("full_cycles_to_done", cyc, 32'd96);
        check("full_checksum", {16'd0, checksum_a}, 32'h0000_F1F0);
        check("full_busy_after", {31'd0, busy_a}, 32'd0);
        check("full_mem_addr_end", {27'd0, mem_addr_a}, 32'd31);

        // Restart from DONE with all-ones data: checksum wraps.
        for (int i = 0; i < 32; i++) mem_a[i] = 16'hFFFF;
        push_range(0, 31);
        start_pulse_a();
        check("restart_checksum_cleared", {16'd0, checksum_a}, 32'd0);
        check("restart_done_cleared", {31'd0, done_a}, 32'd0);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        check("restart_mem_addr", {27'd0, mem_addr_a}, 32'd0);
        wait_done_a(cyc);
        check("ovf_cycles_to_done", cyc, 32'd96);
        check("ovf_checksum", {16'd0, checksum_a}, 32'h0000_FFE0);

        // Backpressure on word 3, ignored start during SEND of word 5.
        for (int i = 0; i < 32; i++) mem_a[i] = 16'(i * 16'h0101);
        push_range(0, 31);
        ready_a = 1'b0;
        start_pulse_a();
        cyc = 1;
        while (!out_valid_a && cyc < 20) begin
            tick();
            cyc++;
        end
        check("first_valid_latency", cyc, 32'd3);
        for (int w = 0; w < 32; w++) begin
            wait_valid_a("bp_word");
            if (w == 3) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("bp_hold_valid", {31'd0, out_valid_a}, 32'd1);
                    check("bp_hold_data", {16'd0, out_data_a}, 32'h0000_0303);
                    check("bp_hold_addr", {27'd0, out_addr_a}, 32'd3);
                    check("bp_hold_mem_addr", {27'd0, mem_addr_a}, 32'd3);
                end
            end
            if (w == 5) begin
                saved_sum = checksum_a;
                start_pulse_a();
                check("ign_start_addr", {27'd0, out_addr_a}, 32'd5);
                check("ign_start_valid", {31'd0, out_valid_a}, 32'd1);
                check("ign_start_checksum", {16'd0, checksum_a}, {16'd0, saved_sum});
                check("ign_start_busy", {31'd0, busy_a}, 32'd1);
            end
            handshake_a();
            if (w == 3) begin
                cyc = 1;
                while (!out_valid_a && cyc < 20) begin
                    tick();
                    cyc++;
                end
                check("bp_next_word_latency", cyc, 32'd3);
            end
        end
        check("bp_done_after_last", {31'd0, done_a}, 32'd1);
        check("bp_checksum", {16'd0, checksum_a}, 32'h0000_F1F0);

        // Reset while word 10 is valid: stream abandoned.
        push_range(0, 9);
        start_pulse_a();
        for (int w = 0; w < 10; w++) begin
            wait_valid_a("rst_word");
            handshake_a();
        end
        wait_valid_a("rst_word10");
        check("rst_word10_addr", {27'd0, out_addr_a}, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", {31'd0, out_valid_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_checksum", {16'd0, checksum_a}, 32'd0);
        check("midrst_mem_addr", {27'd0, mem_addr_a}, 32'd0);
        check("midrst_last", {31'd0, out_last_a}, 32'd0);
        repeat (4) tick();
        check("midrst_stays_idle", {30'd0, busy_a, out_valid_a}, 32'd0);

        // Single-word range instance.
        begin
            beat_t b;
            b.addr = 5'd7;
            b.data = 16'hBEEF;
            b.last = 1'b1;
            q_b.push_back(b);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!out_valid_b && cyc < 20) begin
            tick();
            cyc++;
        end
        check("single_valid_seen", {31'd0, out_valid_b}, 32'd1);
        tick();
        check("single_done_next", {31'd0, done_b}, 32'd1);
        check("single_checksum", {16'd0, checksum_b}, 32'h0000_BEEF);
        check("single_valid_cleared", {31'd0, out_valid_b}, 32'd0);

        tick();
        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
